// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   N_REQ    : number of requesters (fixed at 4)
//   ID_W     : width of a requester index
//   req_id_t : requester index type
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef logic [ID_W-1:0] req_id_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick over four requesters.
// Scans ptr_i, ptr_i+1, ptr_i+2, ptr_i+3 (mod 4) and returns the first valid index.
//   valid_i : per-requester valid
//   ptr_i   : highest-priority requester this cycle
//   any_o   : at least one requester valid
//   id_o    : winning requester index (0 when any_o is low)
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid_i,
    input  req_id_t          ptr_i,
    output logic             any_o,
    output req_id_t          id_o
);

    req_id_t idx;

    always_comb begin
        any_o = |valid_i;
        id_o  = '0;
        idx   = '0;
        // Walk from the farthest offset down so the nearest valid offset wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + req_id_t'(k);
            if (valid_i[idx]) begin
                id_o = idx;
            end
        end
    end

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Four valid/ready requesters sharing one 4:1 data mux, arbitrated round-robin,
// feeding a single-entry registered output stage.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   in_valid_i   : per-requester valid
//   in_data_i    : packed requester words, requester i at [i*WIDTH +: WIDTH]
//   in_ready_o   : per-requester ready, one-hot or zero
//   out_valid_o  : output word valid
//   out_data_o   : registered selected word
//   out_id_o     : requester that produced out_data_o
//   out_ready_i  : consumer accepts the output word
module mux_4_1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       in_valid_i,
    input  logic [N_REQ*WIDTH-1:0] in_data_i,
    output logic [N_REQ-1:0]       in_ready_o,
    output logic                   out_valid_o,
    output logic [WIDTH-1:0]       out_data_o,
    output req_id_t                out_id_o,
    input  logic                   out_ready_i
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    req_id_t          id_q, id_d;
    req_id_t          ptr_q, ptr_d;

    logic             any_req;
    req_id_t          win_id;
    logic             slot_free;
    logic             load;
    logic [WIDTH-1:0] sel_data;

    rr_pick_4 u_pick (
        .valid_i (in_valid_i),
        .ptr_i   (ptr_q),
        .any_o   (any_req),
        .id_o    (win_id)
    );

    // A pop and a new load may share the same edge.
    assign slot_free = !valid_q || out_ready_i;
    assign load      = slot_free && any_req;

    // Only the selected lane is read, so X on other lanes cannot reach the register.
    always_comb begin
        sel_data = '0;
        unique case (win_id)
            2'd0: sel_data = in_data_i[0*WIDTH +: WIDTH];
            2'd1: sel_data = in_data_i[1*WIDTH +: WIDTH];
            2'd2: sel_data = in_data_i[2*WIDTH +: WIDTH];
            2'd3: sel_data = in_data_i[3*WIDTH +: WIDTH];
            default: sel_data = '0;
        endcase
    end

    always_comb begin
        in_ready_o = '0;
        if (load) begin
            in_ready_o = N_REQ'(1) << win_id;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sel_data;
            id_d    = win_id;
            ptr_d   = win_id + 2'd1;  // wraps 3 -> 0
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_id_o    = id_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
module tb_mux_4_1_rr_arbiter;

    localparam int W = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_id;
    logic          out_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_id;
    int         m_ptr;

    mux_4_1_rr_arbiter #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_id_o    (out_id),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester with valid set, scanning from p upward mod 4; -1 when none.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock: drive inputs, check in_ready, clock, advance model, check outputs.
    task automatic step(input logic r, input logic [3:0] v, input logic [4*W-1:0] d,
                        input logic ordy);
        int   win;
        bit   ld;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        win = pick(v, m_ptr);
        ld  = (!m_valid || ordy) && (win >= 0);
        exp_rdy = ld ? 4'(1 << win) : 4'b0000;
        chk("in_ready", 16'(in_ready), 16'(exp_rdy));
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
        end else if (ld) begin
            m_valid = 1; m_data = d[win*W +: W]; m_id = win; m_ptr = (win + 1) % 4;
        end else if (ordy && m_valid) begin
            m_valid = 0;
        end
        chk("out_valid", 16'(out_valid), 16'(m_valid));
        chk("out_data", 16'(out_data), 16'(m_data));
        chk("out_id", 16'(out_id), 16'(m_id));
    endtask

    initial begin
        logic [4*W-1:0] abcd;
        logic [4*W-1:0] xlanes;
        logic [4*W-1:0] rd;
        m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0;
        rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
        abcd = 16'h4321;

        // Reset, then idle
        step(1, 4'b0000, '0, 0);
        step(1, 4'b0000, '0, 0);
        chk("rst_valid", 16'(out_valid), 16'h0);
        chk("rst_data", 16'(out_data), 16'h0);
        chk("rst_id", 16'(out_id), 16'h0);
        for (int i = 0; i < 3; i++) step(0, 4'b0000, '0, 1);
        chk("idle_valid", 16'(out_valid), 16'h0);

        // All requesting, sink always ready: ids 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, abcd, 1);
            chk("rr_id", 16'(out_id), 16'(i % 4));
            chk("rr_data", 16'(out_data), 16'((i % 4) + 1));
            chk("rr_valid", 16'(out_valid), 16'h1);
        end

        // Backpressure: word 5 from requester 2, held three stalled cycles
        step(0, 4'b0100, 16'h0500, 1);
        chk("bp_load_id", 16'(out_id), 16'h2);
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b1111, abcd, 0);
            chk("bp_hold_data", 16'(out_data), 16'h5);
            chk("bp_hold_id", 16'(out_id), 16'h2);
        end
        step(0, 4'b1111, abcd, 1);
        chk("bp_release_id", 16'(out_id), 16'h3);

        // Pointer wrap and sparse requests
        step(0, 4'b0010, abcd, 1);
        chk("sparse_id1", 16'(out_id), 16'h1);
        step(0, 4'b0011, abcd, 1);
        chk("wrap_id0", 16'(out_id), 16'h0);

        // Simultaneous pop and load, X on unselected lanes
        xlanes = {4'hx, 4'hx, 4'h7, 4'hx};
        step(0, 4'b0010, xlanes, 1);
        chk("popload_valid", 16'(out_valid), 16'h1);
        chk("popload_data", 16'(out_data), 16'h7);
        chk("popload_id", 16'(out_id), 16'h1);

        // Reset mid-stall
        step(0, 4'b1000, 16'h9000, 1);
        chk("stall9_data", 16'(out_data), 16'h9);
        step(0, 4'b1111, abcd, 0);
        step(1, 4'b1111, abcd, 0);
        chk("midrst_valid", 16'(out_valid), 16'h0);
        step(0, 4'b1111, abcd, 1);
        chk("postrst_id", 16'(out_id), 16'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rd = 16'($urandom);
            step(($urandom_range(0, 49) == 0), 4'($urandom), rd, ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
